calc_sequencer: RTL

Sequencing controller for the 6-bit calculator ALU. It collects operand A, operand B and a 4-bit operation code from one shared data entry port, one per `enter` press. It then drives the ALU inputs in a fixed order, waits a programmable settle time and latches the result and carry into holding registers. It sits between the keypad/switch front end and the combinational ALU, and supports chaining a result back in as the next operand A.

---
 rtl/calc_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Sequencing controller for the calculator ALU. It collects operand A,
// operand B and an opcode from a shared entry port, one value per button
// press. It then presents the opcode and operands to a combinational ALU,
// waits a fixed settle time and captures the result and carry.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_clear        synchronous abort back to the reset state
//   i_enter        debounced, synchronous button level; only its rising edge acts
//   i_chain        in DONE, selects the previous result as the next operand A
//   i_data_in      operand value, or opcode in bits [3:0]
//   i_alu_c        ALU result
//   i_alu_carry    ALU carry
//   o_alu_a        operand A to the ALU (zero outside EXEC/DONE)
//   o_alu_b        operand B to the ALU (zero outside EXEC/DONE)
//   o_alu_control  opcode to the ALU
//   o_result       captured result
//   o_carry_out    captured carry
//   o_busy         high in EXEC
//   o_done         high in DONE
//   o_error        high in ERR
//   o_state_code   GET_A=0, GET_B=1, GET_OP=2, EXEC=3, DONE=4, ERR=5
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter int unsigned Word_Length   = 6,
    parameter int unsigned Settle_Cycles = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_enter,
    input  logic                   i_chain,
    input  logic [Word_Length-1:0] i_data_in,
    input  logic [Word_Length-1:0] i_alu_c,
    input  logic                   i_alu_carry,
    output logic [Word_Length-1:0] o_alu_a,
    output logic [Word_Length-1:0] o_alu_b,
    output logic [3:0]             o_alu_control,
    output logic [Word_Length-1:0] o_result,
    output logic                   o_carry_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [2:0]             o_state_code
);

    // Counter is one value wider than needed so it never wraps inside EXEC.
    localparam int unsigned CNT_W  = $clog2(Settle_Cycles + 2);
    localparam logic [3:0]  OP_MAX = 4'd9;

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_enter_q;
    logic [Word_Length-1:0] r_a_reg;
    logic [Word_Length-1:0] r_b_reg;
    logic [CNT_W-1:0]       r_cnt;
    logic [Word_Length-1:0] r_alu_a;
    logic [Word_Length-1:0] r_alu_b;
    logic [3:0]             r_alu_control;
    logic [Word_Length-1:0] r_result;
    logic                   r_carry_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic                   w_press;
    logic                   w_op_ok;
    logic                   w_cnt_hit;
    logic                   w_ops_keep;

    // One-cycle press pulse per rising edge of the button level.
    assign w_press   = i_enter & ~r_enter_q;
    assign w_op_ok   = (i_data_in[3:0] <= OP_MAX);
    assign w_cnt_hit = (r_cnt == CNT_W'(Settle_Cycles));
    // ALU operands are only visible while executing or showing a result.
    assign w_ops_keep = (w_state_nxt == S_EXEC) || (w_state_nxt == S_DONE);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_GET_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition including a press.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_GET_A;
        end else begin
            case (r_state)
                S_GET_A: begin
                    if (w_press) begin
                        w_state_nxt = S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (w_press) begin
                        w_state_nxt = S_GET_OP;
                    end
                end
                S_GET_OP: begin
                    if (w_press) begin
                        w_state_nxt = w_op_ok ? S_EXEC : S_ERR;
                    end
                end
                S_EXEC: begin
                    if (w_cnt_hit) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_press) begin
                        w_state_nxt = S_GET_B;
                    end
                end
                S_ERR: begin
                    if (w_press) begin
                        w_state_nxt = S_GET_OP;
                    end
                end
                default: begin
                    w_state_nxt = S_GET_A;
                end
            endcase
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_enter_q     <= 1'b0;
            r_a_reg       <= '0;
            r_b_reg       <= '0;
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_result      <= '0;
            r_carry_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else if (i_clear) begin
            r_enter_q     <= 1'b0;
            r_a_reg       <= '0;
            r_b_reg       <= '0;
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_result      <= '0;
            r_carry_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_enter_q <= i_enter;
            r_busy    <= (w_state_nxt == S_EXEC);
            r_done    <= (w_state_nxt == S_DONE);
            r_error   <= (w_state_nxt == S_ERR);

            if (!w_ops_keep) begin
                r_alu_a <= '0;
                r_alu_b <= '0;
            end

            case (r_state)
                S_GET_A: begin
                    if (w_press) begin
                        r_a_reg <= i_data_in;
                    end
                end
                S_GET_B: begin
                    if (w_press) begin
                        r_b_reg <= i_data_in;
                    end
                end
                S_GET_OP: begin
                    // Opcode goes out one clock ahead of the operands.
                    if (w_press && w_op_ok) begin
                        r_alu_control <= i_data_in[3:0];
                        r_cnt         <= '0;
                    end
                end
                S_EXEC: begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_alu_a <= r_a_reg;
                    r_alu_b <= r_b_reg;
                    if (w_cnt_hit) begin
                        r_result    <= i_alu_c;
                        r_carry_out <= i_alu_carry;
                    end
                end
                S_DONE: begin
                    if (w_press) begin
                        r_a_reg <= i_chain ? r_result : i_data_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_control = r_alu_control;
    assign o_result      = r_result;
    assign o_carry_out   = r_carry_out;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_state_code  = r_state;

endmodule
